memory_stage: RTL and testbench

//  Pipeline stage directly downstream of the execute stage: EX/MEM register, data memory, MEM/WB register.

---
 rtl/memory_stage.sv | 128 ++++++++++++
 tb/tb_memory_stage.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// memory_stage: EX/MEM register, data memory and MEM/WB register.
// Resolves branches, performs loads/stores, presents write-back data.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_stall          hold both pipeline registers, suppress memory write
//   in_flush          load a bubble into EX/MEM
//   in_*              execute-stage results and control bits
//   O_PCSrc           branch taken (EX/MEM Branch & Zero)
//   O_BranchTarget    EX/MEM branch target
//   O_ReadData        MEM/WB load data
//   O_ALUResult       MEM/WB ALU result
//   O_WriteRegister   MEM/WB destination register
//   O_RegWrite        MEM/WB write-back enable
//   O_WB_Data         selected write-back data
module memory_stage #(
    parameter int DATA_W = 16,
    parameter int REG_W  = 3,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_stall,
    input  logic              in_flush,
    input  logic [DATA_W-1:0] in_ALUResult,
    input  logic              in_Zero,
    input  logic [DATA_W-1:0] in_BranchTarget,
    input  logic [REG_W-1:0]  in_WriteRegister,
    input  logic [DATA_W-1:0] in_Write_Data,
    input  logic              in_MemRead,
    input  logic              in_MemWrite,
    input  logic              in_Branch,
    input  logic              in_RegWrite,
    input  logic              in_MemtoReg,
    output logic              O_PCSrc,
    output logic [DATA_W-1:0] O_BranchTarget,
    output logic [DATA_W-1:0] O_ReadData,
    output logic [DATA_W-1:0] O_ALUResult,
    output logic [REG_W-1:0]  O_WriteRegister,
    output logic              O_RegWrite,
    output logic [DATA_W-1:0] O_WB_Data
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef struct packed {
        logic [DATA_W-1:0] alu;
        logic              zero;
        logic [DATA_W-1:0] target;
        logic [REG_W-1:0]  wreg;
        logic [DATA_W-1:0] wdata;
        logic              mem_read;
        logic              mem_write;
        logic              branch;
        logic              reg_write;
        logic              mem_to_reg;
    } ex_mem_t;

    typedef struct packed {
        logic [DATA_W-1:0] read_data;
        logic [DATA_W-1:0] alu;
        logic [REG_W-1:0]  wreg;
        logic              reg_write;
        logic              mem_to_reg;
    } mem_wb_t;

    ex_mem_t ex_mem;
    ex_mem_t ex_mem_d;
    mem_wb_t mem_wb;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] addr;

    // Byte address to word address; upper bits drop so addresses wrap.
    assign addr = ex_mem.alu[ADDR_W:1];

    // Next EX/MEM contents; a flush keeps data but kills every control
    // bit that could change architectural state or redirect fetch.
    always_comb begin
        ex_mem_d            = '0;
        ex_mem_d.alu        = in_ALUResult;
        ex_mem_d.zero       = in_Zero;
        ex_mem_d.target     = in_BranchTarget;
        ex_mem_d.wreg       = in_WriteRegister;
        ex_mem_d.wdata      = in_Write_Data;
        ex_mem_d.mem_to_reg = in_MemtoReg;
        if (!in_flush) begin
            ex_mem_d.mem_read  = in_MemRead;
            ex_mem_d.mem_write = in_MemWrite;
            ex_mem_d.branch    = in_Branch;
            ex_mem_d.reg_write = in_RegWrite;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_mem <= '0;
            mem_wb <= '0;
        end else if (!in_stall) begin
            ex_mem            <= ex_mem_d;
            mem_wb.alu        <= ex_mem.alu;
            mem_wb.wreg       <= ex_mem.wreg;
            mem_wb.reg_write  <= ex_mem.reg_write;
            mem_wb.mem_to_reg <= ex_mem.mem_to_reg;
            // Read enable: load data is only meaningful for loads.
            if (ex_mem.mem_read) begin
                mem_wb.read_data <= mem[addr];
            end
        end
    end

    // Memory array has no reset; writes only on a live, unstalled edge.
    always_ff @(posedge clk) begin
        if (!rst && !in_stall && ex_mem.mem_write) begin
            mem[addr] <= ex_mem.wdata;
        end
    end

    assign O_PCSrc         = ex_mem.branch & ex_mem.zero;
    assign O_BranchTarget  = ex_mem.target;
    assign O_ReadData      = mem_wb.read_data;
    assign O_ALUResult     = mem_wb.alu;
    assign O_WriteRegister = mem_wb.wreg;
    assign O_RegWrite      = mem_wb.reg_write;
    assign O_WB_Data       = mem_wb.mem_to_reg ? mem_wb.read_data
                                               : mem_wb.alu;

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: self-checking bench for memory_stage.
// Write-back results are scoreboarded; features checked per task.
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_stall = 1'b0;
    logic        in_flush = 1'b0;
    logic [15:0] in_ALUResult = '0;
    logic        in_Zero = 1'b0;
    logic [15:0] in_BranchTarget = '0;
    logic [2:0]  in_WriteRegister = '0;
    logic [15:0] in_Write_Data = '0;
    logic        in_MemRead = 1'b0;
    logic        in_MemWrite = 1'b0;
    logic        in_Branch = 1'b0;
    logic        in_RegWrite = 1'b0;
    logic        in_MemtoReg = 1'b0;
    logic        O_PCSrc;
    logic [15:0] O_BranchTarget;
    logic [15:0] O_ReadData;
    logic [15:0] O_ALUResult;
    logic [2:0]  O_WriteRegister;
    logic        O_RegWrite;
    logic [15:0] O_WB_Data;

    int checks = 0;
    int errors = 0;

    logic [18:0] exp_q [$];
    logic [15:0] model [256];
    logic        adv_q = 1'b0;

    memory_stage #(
        .DATA_W(16),
        .REG_W (3),
        .ADDR_W(8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .in_stall        (in_stall),
        .in_flush        (in_flush),
        .in_ALUResult    (in_ALUResult),
        .in_Zero         (in_Zero),
        .in_BranchTarget (in_BranchTarget),
        .in_WriteRegister(in_WriteRegister),
        .in_Write_Data   (in_Write_Data),
        .in_MemRead      (in_MemRead),
        .in_MemWrite     (in_MemWrite),
        .in_Branch       (in_Branch),
        .in_RegWrite     (in_RegWrite),
        .in_MemtoReg     (in_MemtoReg),
        .O_PCSrc         (O_PCSrc),
        .O_BranchTarget  (O_BranchTarget),
        .O_ReadData      (O_ReadData),
        .O_ALUResult     (O_ALUResult),
        .O_WriteRegister (O_WriteRegister),
        .O_RegWrite      (O_RegWrite),
        .O_WB_Data       (O_WB_Data)
    );

    always #5 clk = ~clk;

    // Whether the last rising edge advanced MEM/WB.
    always @(posedge clk) adv_q <= !rst && !in_stall;

    // Scoreboard: every advancing edge that presents a write-back pops.
    always @(negedge clk) begin
        logic [18:0] e;
        if (adv_q && O_RegWrite) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wb_unexpected: got rd=%0d data=%h, required no write-back",
                         O_WriteRegister, O_WB_Data);
            end else begin
                e = exp_q.pop_front();
                if ({O_WriteRegister, O_WB_Data} !== e) begin
                    errors++;
                    $display("FAIL wb_data: got rd=%0d data=%h, required rd=%0d data=%h",
                             O_WriteRegister, O_WB_Data, e[18:16], e[15:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_nop();
        in_stall = 1'b0;
        in_flush = 1'b0;
        in_ALUResult = '0;
        in_Zero = 1'b0;
        in_BranchTarget = '0;
        in_WriteRegister = '0;
        in_Write_Data = '0;
        in_MemRead = 1'b0;
        in_MemWrite = 1'b0;
        in_Branch = 1'b0;
        in_RegWrite = 1'b0;
        in_MemtoReg = 1'b0;
    endtask

    // Drive one instruction for one clock and record its expected effect.
    task automatic issue(input logic [15:0] alu, input logic [15:0] wdata,
                         input logic [2:0] rd, input logic mr,
                         input logic mw, input logic rw, input logic m2r);
        logic [7:0] w;
        set_nop();
        in_ALUResult = alu;
        in_Write_Data = wdata;
        in_WriteRegister = rd;
        in_MemRead = mr;
        in_MemWrite = mw;
        in_RegWrite = rw;
        in_MemtoReg = m2r;
        w = alu[8:1];
        if (rw) exp_q.push_back({rd, m2r ? model[w] : alu});
        if (mw) model[w] = wdata;
        tick();
    endtask

    task automatic test_reset();
        set_nop();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({O_PCSrc, O_BranchTarget, O_ReadData, O_ALUResult,
             O_WriteRegister, O_RegWrite, O_WB_Data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got pcsrc=%b tgt=%h rd=%h alu=%h wr=%0d rw=%b wb=%h, required all 0",
                     O_PCSrc, O_BranchTarget, O_ReadData, O_ALUResult,
                     O_WriteRegister, O_RegWrite, O_WB_Data);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_store_load();
        issue(16'h0010, 16'hBEEF, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        issue(16'h0010, 16'h0000, 3'd3, 1'b1, 1'b0, 1'b1, 1'b1);
        set_nop();
        tick();
        checks++;
        if (O_WB_Data !== 16'hBEEF) begin
            errors++;
            $display("FAIL st_ld_data: got %h, required BEEF", O_WB_Data);
        end
        checks++;
        if (O_WriteRegister !== 3'd3) begin
            errors++;
            $display("FAIL st_ld_rd: got %0d, required 3", O_WriteRegister);
        end
        checks++;
        if (O_RegWrite !== 1'b1) begin
            errors++;
            $display("FAIL st_ld_rw: got %b, required 1", O_RegWrite);
        end
    endtask

    task automatic test_branch();
        set_nop();
        in_Branch = 1'b1;
        in_Zero = 1'b1;
        in_BranchTarget = 16'h0042;
        tick();
        checks++;
        if (O_PCSrc !== 1'b1) begin
            errors++;
            $display("FAIL br_taken: got %b, required 1", O_PCSrc);
        end
        checks++;
        if (O_BranchTarget !== 16'h0042) begin
            errors++;
            $display("FAIL br_target: got %h, required 0042", O_BranchTarget);
        end
        in_Zero = 1'b0;
        in_BranchTarget = 16'h0077;
        tick();
        checks++;
        if (O_PCSrc !== 1'b0) begin
            errors++;
            $display("FAIL br_not_taken: got %b, required 0", O_PCSrc);
        end
        set_nop();
        tick();
    endtask

    task automatic test_stall();
        issue(16'h0099, 16'h0000, 3'd5, 1'b0, 1'b0, 1'b1, 1'b0);
        issue(16'h0004, 16'h1234, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        in_stall = 1'b1;
        in_MemWrite = 1'b1;
        in_ALUResult = 16'h0004;
        in_Write_Data = 16'h5678;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({O_WB_Data, O_WriteRegister, O_RegWrite, O_PCSrc} !==
                {16'h0099, 3'd5, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL stall_frozen[%0d]: got wb=%h rd=%0d rw=%b pcsrc=%b, required wb=0099 rd=5 rw=1 pcsrc=0",
                         i, O_WB_Data, O_WriteRegister, O_RegWrite, O_PCSrc);
            end
        end
        set_nop();
        tick();
        issue(16'h0004, 16'h0000, 3'd2, 1'b1, 1'b0, 1'b1, 1'b1);
        set_nop();
        tick();
        checks++;
        if (O_WB_Data !== 16'h1234) begin
            errors++;
            $display("FAIL stall_store_once: got %h, required 1234", O_WB_Data);
        end
    endtask

    task automatic test_flush();
        issue(16'h0008, 16'h0000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        set_nop();
        in_flush = 1'b1;
        in_ALUResult = 16'h0008;
        in_Write_Data = 16'hAAAA;
        in_MemWrite = 1'b1;
        in_Branch = 1'b1;
        in_Zero = 1'b1;
        in_RegWrite = 1'b1;
        in_WriteRegister = 3'd7;
        tick();
        checks++;
        if (O_PCSrc !== 1'b0) begin
            errors++;
            $display("FAIL flush_pcsrc: got %b, required 0", O_PCSrc);
        end
        set_nop();
        tick();
        checks++;
        if (O_RegWrite !== 1'b0) begin
            errors++;
            $display("FAIL flush_regwrite: got %b, required 0", O_RegWrite);
        end
        issue(16'h0008, 16'h0000, 3'd1, 1'b1, 1'b0, 1'b1, 1'b1);
        set_nop();
        tick();
        checks++;
        if (O_WB_Data !== 16'h0000) begin
            errors++;
            $display("FAIL flush_no_store: got %h, required 0000", O_WB_Data);
        end
    endtask

    task automatic test_wrap();
        issue(16'h0200, 16'h7777, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        issue(16'h0000, 16'h0000, 3'd4, 1'b1, 1'b0, 1'b1, 1'b1);
        set_nop();
        tick();
        checks++;
        if (O_WB_Data !== 16'h7777) begin
            errors++;
            $display("FAIL addr_wrap: got %h, required 7777", O_WB_Data);
        end
    endtask

    task automatic test_reset_store();
        issue(16'h0030, 16'h3C3C, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        set_nop();
        in_ALUResult = 16'h0030;
        in_Write_Data = 16'h5A5A;
        in_MemWrite = 1'b1;
        in_BranchTarget = 16'h00F0;
        in_Branch = 1'b1;
        in_Zero = 1'b1;
        tick();
        set_nop();
        rst = 1'b1;
        tick();
        checks++;
        if ({O_PCSrc, O_BranchTarget, O_ReadData, O_ALUResult,
             O_WriteRegister, O_RegWrite, O_WB_Data} !== '0) begin
            errors++;
            $display("FAIL rst_inflight_outputs: got pcsrc=%b tgt=%h rd=%h alu=%h wr=%0d rw=%b wb=%h, required all 0",
                     O_PCSrc, O_BranchTarget, O_ReadData, O_ALUResult,
                     O_WriteRegister, O_RegWrite, O_WB_Data);
        end
        rst = 1'b0;
        exp_q.delete();
        issue(16'h0030, 16'h0000, 3'd6, 1'b1, 1'b0, 1'b1, 1'b1);
        set_nop();
        tick();
        checks++;
        if (O_WB_Data !== 16'h3C3C) begin
            errors++;
            $display("FAIL rst_store_dropped: got %h, required 3C3C", O_WB_Data);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] a;
        for (int i = 0; i < 8; i++) begin
            a = 16'h0080 + 16'(2 * i);
            issue(a, 16'($urandom), 3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        for (int i = 0; i < 8; i++) begin
            a = 16'h0080 + 16'(2 * (7 - i));
            issue(a, 16'h0000, 3'(i), 1'b1, 1'b0, 1'b1, 1'b1);
            issue(16'($urandom), 16'h0000, 3'd7, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        set_nop();
        repeat (3) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL wb_drain: got %0d pending write-backs, required 0",
                     exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_branch();
        test_stall();
        test_flush();
        test_wrap();
        test_reset_store();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
